// File: rtl/clock_gating_controller_pkg.sv
// Shared types and helpers for the clock gating controller.
package clock_gating_controller_pkg;

  // Controller phases: clock running, sleep handshake, clock stopped, clock restarting.
  typedef enum logic [1:0] {
    RUNNING,
    REQUEST,
    GATED,
    WAKING
  } state_t;

  // Width of the shared idle/wake counter: wide enough to hold max(idle, wake).
  function automatic int unsigned counter_width(input int unsigned idle_cycles,
                                                input int unsigned wake_cycles);
    int unsigned max_count;
    max_count = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    if (max_count == 0) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/clock_gating_controller.sv
// Clock gating controller: drives the gater enable from downstream idleness, with a
// sleep request/acknowledge handshake and a timed wake-up before reporting 'awake'.
// Runs on the free-running clock; every output is a flop so the gater latch only ever
// sees enable changes at clock edges.
module clock_gating_controller
  import clock_gating_controller_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic busy,
  input  logic wake_request,
  input  logic force_on,
  input  logic sleep_acknowledge,
  output logic sleep_request,
  output logic gate_enable,
  output logic awake
);

  localparam int unsigned COUNTER_WIDTH = counter_width(IDLE_CYCLES, WAKE_CYCLES);

  // Terminal counts; the wake one is only reachable when WAKE_CYCLES > 0.
  localparam int unsigned WakeLastInt = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
  localparam logic [COUNTER_WIDTH-1:0] IdleLast = COUNTER_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] WakeLast = COUNTER_WIDTH'(WakeLastInt);
  localparam logic [COUNTER_WIDTH-1:0] CountOne = COUNTER_WIDTH'(1);

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_sleep_request;
  logic                     r_gate_enable;
  logic                     r_awake;

  logic w_wake;
  logic w_activity;
  logic w_idle_done;
  logic w_wake_done;

  assign w_wake      = wake_request | force_on;
  assign w_activity  = busy | w_wake;
  assign w_idle_done = (r_counter == IdleLast);
  assign w_wake_done = (r_counter == WakeLast);

  // Single FSM: one counter times both the idle run and the wake-up settle period.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= RUNNING;
      r_counter       <= '0;
      r_sleep_request <= 1'b0;
      r_gate_enable   <= 1'b1;
      r_awake         <= 1'b1;
    end else begin
      unique case (r_state)
        RUNNING: begin
          if (w_activity) begin
            r_counter <= '0;
          end else if (w_idle_done) begin
            r_state         <= REQUEST;
            r_sleep_request <= 1'b1;
            r_counter       <= '0;
          end else begin
            r_counter <= r_counter + CountOne;
          end
        end
        REQUEST: begin
          // Abort wins over acknowledge in the same cycle.
          if (w_activity) begin
            r_state         <= RUNNING;
            r_sleep_request <= 1'b0;
            r_counter       <= '0;
          end else if (sleep_acknowledge) begin
            r_state         <= GATED;
            r_sleep_request <= 1'b0;
            r_gate_enable   <= 1'b0;
            r_awake         <= 1'b0;
            r_counter       <= '0;
          end
        end
        GATED: begin
          // busy is meaningless here: the downstream logic has no clock.
          if (w_wake) begin
            r_gate_enable <= 1'b1;
            r_counter     <= '0;
            if (WAKE_CYCLES == 0) begin
              r_state <= RUNNING;
              r_awake <= 1'b1;
            end else begin
              r_state <= WAKING;
            end
          end
        end
        WAKING: begin
          if (w_wake_done) begin
            r_state   <= RUNNING;
            r_awake   <= 1'b1;
            r_counter <= '0;
          end else begin
            r_counter <= r_counter + CountOne;
          end
        end
      endcase
    end
  end

  assign sleep_request = r_sleep_request;
  assign gate_enable   = r_gate_enable;
  assign awake         = r_awake;

endmodule

// File: tb/tb_clock_gating_controller.sv
// Scoreboard bench for clock_gating_controller: two instances (IDLE=4/WAKE=2 and
// IDLE=1/WAKE=0) share stimulus; a phase-level model predicts outputs per edge.
module tb_clock_gating_controller;

  localparam int unsigned Idle0 = 4;
  localparam int unsigned Wake0 = 2;
  localparam int unsigned Idle1 = 1;
  localparam int unsigned Wake1 = 0;

  logic clock = 1'b0;
  logic reset, busy, wake_request, force_on, sleep_acknowledge;
  logic sreq0, gen0, awake0;
  logic sreq1, gen1, awake1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  clock_gating_controller #(
    .IDLE_CYCLES(Idle0),
    .WAKE_CYCLES(Wake0)
  ) dut0 (
    .clock            (clock),
    .reset            (reset),
    .busy             (busy),
    .wake_request     (wake_request),
    .force_on         (force_on),
    .sleep_acknowledge(sleep_acknowledge),
    .sleep_request    (sreq0),
    .gate_enable      (gen0),
    .awake            (awake0)
  );

  clock_gating_controller #(
    .IDLE_CYCLES(Idle1),
    .WAKE_CYCLES(Wake1)
  ) dut1 (
    .clock            (clock),
    .reset            (reset),
    .busy             (busy),
    .wake_request     (wake_request),
    .force_on         (force_on),
    .sleep_acknowledge(sleep_acknowledge),
    .sleep_request    (sreq1),
    .gate_enable      (gen1),
    .awake            (awake1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: idle run length, handshake flag, gated flag, remaining settle time.
  typedef struct {
    bit requesting;
    bit gated;
    int idle_run;
    int wake_left;
    bit gate;
    bit awake;
    bit req;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit rst, input bit b, input bit wr,
                                input bit fo, input bit ak, input int idle, input int wake);
    mdl_t n;
    bit   wk;
    bit   act;
    n   = m;
    wk  = wr | fo;
    act = b | wk;
    if (rst) begin
      n = '{requesting: 0, gated: 0, idle_run: 0, wake_left: 0, gate: 1, awake: 1, req: 0};
    end else if (m.wake_left > 0) begin
      n.wake_left = m.wake_left - 1;
      if (n.wake_left == 0) begin
        n.awake    = 1;
        n.idle_run = 0;
      end
    end else if (m.gated) begin
      if (wk) begin
        n.gated    = 0;
        n.gate     = 1;
        n.idle_run = 0;
        if (wake == 0) n.awake = 1;
        else n.wake_left = wake;
      end
    end else if (m.requesting) begin
      if (act) begin
        n.requesting = 0;
        n.req        = 0;
        n.idle_run   = 0;
      end else if (ak) begin
        n.requesting = 0;
        n.gated      = 1;
        n.gate       = 0;
        n.awake      = 0;
        n.req        = 0;
      end
    end else begin
      if (act) begin
        n.idle_run = 0;
      end else begin
        n.idle_run = m.idle_run + 1;
        if (n.idle_run >= idle) begin
          n.requesting = 1;
          n.req        = 1;
          n.idle_run   = 0;
        end
      end
    end
    return n;
  endfunction

  mdl_t m0 = '{requesting: 0, gated: 0, idle_run: 0, wake_left: 0, gate: 1, awake: 1, req: 0};
  mdl_t m1 = '{requesting: 0, gated: 0, idle_run: 0, wake_left: 0, gate: 1, awake: 1, req: 0};

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic drive(input bit rst, input bit b, input bit wr, input bit fo, input bit ak);
    @(negedge clock);
    reset             = rst;
    busy              = b;
    wake_request      = wr;
    force_on          = fo;
    sleep_acknowledge = ak;
    m0 = step(m0, rst, b, wr, fo, ak, Idle0, Wake0);
    m1 = step(m1, rst, b, wr, fo, ak, Idle1, Wake1);
    q0.push_back({m0.req, m0.gate, m0.awake});
    q1.push_back({m1.req, m1.gate, m1.awake});
  endtask

  // Monitor: compare registered outputs just after each active edge.
  always @(posedge clock) begin
    #1;
    if (q0.size() > 0) chk("dut0 {sreq,gen,awake}", {29'd0, sreq0, gen0, awake0}, {29'd0, q0.pop_front()});
    if (q1.size() > 0) chk("dut1 {sreq,gen,awake}", {29'd0, sreq1, gen1, awake1}, {29'd0, q1.pop_front()});
  end

  // Behavioural latch-based gater fed by dut0, used for frequency and glitch checks.
  logic en_lat = 1'b0;
  logic gclk;
  always @(clock or gen0) if (!clock) en_lat = gen0;
  assign gclk = clock & en_lat;

  int  gclk_cnt   = 0;
  bit  glitch_chk = 0;
  time t_rise     = 0;
  always @(posedge gclk) begin
    gclk_cnt++;
    t_rise = $time;
  end
  always @(negedge gclk) begin
    if (glitch_chk) chk("gclk high phase", 32'($time - t_rise), 32'd5);
  end

  initial begin
    reset = 1'b1; busy = 1'b0; wake_request = 1'b0; force_on = 1'b0; sleep_acknowledge = 1'b0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    glitch_chk = 1;

    // Busy domain stays clocked.
    repeat (20) drive(0, 1, 0, 0, 1);

    // Idle with acknowledge: request then gate; gated clock must be silent.
    repeat (6) drive(0, 0, 0, 0, 1);
    gclk_cnt = 0;
    repeat (10) drive(0, 0, 0, 0, 1);
    chk("gclk edges while gated", 32'(gclk_cnt), 32'd0);

    // Wake pulse, then keep busy: full-rate gated clock once running.
    drive(0, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    gclk_cnt = 0;
    repeat (10) drive(0, 1, 0, 0, 0);
    chk("gclk edges while running", 32'(gclk_cnt), 32'd10);

    // Abort in REQUEST with busy and acknowledge arriving together.
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    repeat (3) drive(0, 1, 0, 0, 0);

    // force_on blocks sleep, then wakes from GATED.
    repeat (100) drive(0, 0, 0, 1, 1);
    repeat (7) drive(0, 0, 0, 0, 1);
    repeat (5) drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);

    // Reset during WAKING.
    repeat (7) drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0);

    // Reset during REQUEST.
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0);

    // Randomised traffic biased towards idleness so all phases are visited.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 1) == 1));
    end

    @(posedge clock);
    #2;
    chk("dut0 queue drained", 32'(q0.size()), 32'd0);
    chk("dut1 queue drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_gating_controller.md
Name: clock_gating_controller

Overview:
- Sequential controller that produces the `enable` input of the clock gater.
- Watches downstream activity and gates the clock after a programmable idle period, using a sleep request/acknowledge handshake with the downstream logic.
- Re-enables the clock on wake request and reports when the gated clock is stable again.
- Runs on the free-running (ungated) clock, next to the clock gater in every gated clock domain.

Parameters:
- IDLE_CYCLES, 16, consecutive idle cycles before sleep is requested; legal range >= 1.
- WAKE_CYCLES, 2, cycles between gate re-enable and `awake` assertion; 0 allowed.
- COUNTER_WIDTH, $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1), derived localparam; not overridable.

Ports:
- clock  input  1  free-running clock, the same clock that feeds the gater's clock_in.
- reset  input  1  synchronous, active-high reset.
- busy  input  1  downstream activity indicator; high means the domain is not idle.
- wake_request  input  1  level request to run the gated clock.
- force_on  input  1  keeps the clock running; blocks sleep and wakes from GATED.
- sleep_acknowledge  input  1  downstream agrees to be gated; sampled only in REQUEST.
- sleep_request  output  1  asks the downstream logic for permission to gate.
- gate_enable  output  1  drives the clock gater `enable`.
- awake  output  1  gated clock is running and stable.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - state = RUNNING, counter = 0.
  - gate_enable = 1, awake = 1, sleep_request = 0.
  - The clock is on out of reset so the downstream logic can reset.
  - Reset mid-operation from any state returns to these values at the next edge.
- Define wake = wake_request | force_on, and activity = busy | wake.
- RUNNING:
  - If activity, counter clears to 0.
  - Otherwise counter increments.
  - When counter == IDLE_CYCLES-1 and there is no activity, go to REQUEST: sleep_request = 1 and counter = 0 from the next cycle.
- REQUEST:
  - If activity, abort: go to RUNNING, sleep_request = 0, counter = 0.
  - Otherwise, if sleep_acknowledge, go to GATED: gate_enable = 0, awake = 0, sleep_request = 0 next cycle.
  - Otherwise hold.
  - Abort has priority over acknowledge when both occur in the same cycle.
- GATED:
  - gate_enable = 0; busy is ignored (the downstream logic is unclocked).
  - On wake, go to WAKING: gate_enable = 1 next cycle, counter = 0.
  - If WAKE_CYCLES == 0, go directly to RUNNING with awake = 1.
- WAKING:
  - gate_enable = 1, awake = 0; counter increments each cycle.
  - When counter == WAKE_CYCLES-1, go to RUNNING: awake = 1 next cycle, counter = 0.
  - Inputs are ignored in this state.
- sleep_acknowledge is ignored outside REQUEST.
- gate_enable only changes at clock edges, so the gater latch sees a stable enable (glitch-free by construction).
- Latency with sleep_acknowledge tied high:
  - sleep_request rises IDLE_CYCLES edges after the last active cycle.
  - gate_enable falls 1 edge later.
- Wake latency:
  - gate_enable rises 1 edge after wake is seen in GATED.
  - awake rises WAKE_CYCLES edges after that.
- Counter saturation is not needed: the counter is reset on every state change.

Decomposition:
- Package clock_gating_controller_pkg holds:
  - typedef enum state_t {RUNNING, REQUEST, GATED, WAKING}.
  - Function computing COUNTER_WIDTH.
- No sub-module: one shared counter serves both the idle and wake phases.
- The clock gater is instantiated by the integrating wrapper, not inside this block.

Test Plan:
- Reset, then busy = 1 for 20 cycles -> gate_enable = 1, awake = 1, sleep_request = 0 throughout.
- IDLE_CYCLES = 4, sleep_acknowledge = 1, busy drops at edge N:
  - sleep_request = 1 after edge N+4.
  - gate_enable = 0 and awake = 0 after edge N+5.
  - Measured gated clock frequency is 0.
- In REQUEST with sleep_acknowledge = 0, raise busy and sleep_acknowledge in the same cycle -> state returns to RUNNING, gate_enable stays 1, sleep_request drops next edge.
- From GATED with WAKE_CYCLES = 2, pulse wake_request at edge M:
  - gate_enable = 1 after edge M+1.
  - awake = 1 after edge M+3.
  - Gated clock frequency equals the input clock frequency.
- Hold force_on = 1 with busy = 0 for 100 cycles -> no sleep_request. Assert force_on in GATED -> wake sequence as above.
- Assert reset during WAKING and during REQUEST -> next edge gives gate_enable = 1, awake = 1, sleep_request = 0. Random busy/wake stimulus for 1000 cycles -> no glitch on the gated clock (every high phase equals half the clock period).
